// File: rtl/instr_fe.sv
// instr_fe: instruction fetch front end.
// Issues one read at a time to instruction memory and presents fetched words
// to decode. It includes a one-entry skid buffer to absorb a response that
// returns while decode is stalled. Redirects and flushes are handled here.
// A response to an abandoned request is drained in the DISCARD state.
//
// Ports
//   clk, rstn          clock, synchronous active-low reset
//   instr_req          memory read request (registered)
//   instr_addr         word address of the request (registered, [1:0] = 0)
//   instr_ack          memory response valid
//   instr_data         memory read data, valid with instr_ack
//   instr, pc          fetched instruction and its address (registered)
//   clk_en             instr/pc valid for decode (registered)
//   stall              decode stall, freezes instr/pc/clk_en
//   flush              drop the current output and the skid entry
//   change_pc, new_pc  redirect request and target
module instr_fe #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  input  logic        instr_ack,
  input  logic [31:0] instr_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        clk_en,
  input  logic        stall,
  input  logic        flush,
  input  logic        change_pc,
  input  logic [31:0] new_pc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP         = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);
  localparam logic [XLEN-1:0] RESET_FETCH = PC_RESET & ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] instr_d, pc_d, instr_addr_d;
  logic            clk_en_d, instr_req_d;
  logic            ack_v;
  logic [XLEN-1:0] redirect_pc;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_valid_d = skid_valid_q;
    instr_d      = instr;
    pc_d         = pc;
    clk_en_d     = clk_en;
    instr_req_d  = 1'b0;
    instr_addr_d = instr_addr;

    // An ack counts only against a request we actually have outstanding.
    ack_v       = instr_req & instr_ack;
    redirect_pc = new_pc & ALIGN_MASK;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (change_pc) fetch_pc_d = redirect_pc;
      end

      FETCH: begin
        if (change_pc) begin
          fetch_pc_d   = redirect_pc;
          skid_valid_d = 1'b0;
          clk_en_d     = 1'b0;
          // A request still in flight must be drained before refetching.
          if (instr_req && !instr_ack) state_d = DISCARD;
        end else if (flush) begin
          // Any returning data is dropped; fetch_pc stays, so it is refetched.
          clk_en_d     = 1'b0;
          skid_valid_d = 1'b0;
        end else if (stall) begin
          if (ack_v) begin
            skid_instr_d = instr_data;
            skid_pc_d    = fetch_pc_q;
            skid_valid_d = 1'b1;
            fetch_pc_d   = fetch_pc_q + PC_STEP;
          end
        end else if (skid_valid_q) begin
          instr_d      = skid_instr_q;
          pc_d         = skid_pc_q;
          clk_en_d     = 1'b1;
          skid_valid_d = 1'b0;
        end else if (ack_v) begin
          instr_d    = instr_data;
          pc_d       = fetch_pc_q;
          clk_en_d   = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
          clk_en_d = 1'b0;
        end
      end

      DISCARD: begin
        clk_en_d     = 1'b0;
        skid_valid_d = 1'b0;
        if (change_pc) fetch_pc_d = redirect_pc;
        if (ack_v) state_d = FETCH;
      end

      default: state_d = IDLE;
    endcase

    // Request for the coming cycle; DISCARD keeps the abandoned address.
    instr_req_d = ((state_d == FETCH) && !skid_valid_d) || (state_d == DISCARD);
    if (state_d != DISCARD) instr_addr_d = fetch_pc_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_FETCH;
      skid_instr_q <= NOP;
      skid_pc_q    <= RESET_FETCH;
      skid_valid_q <= 1'b0;
      instr        <= NOP;
      pc           <= PC_RESET;
      clk_en       <= 1'b0;
      instr_req    <= 1'b0;
      instr_addr   <= RESET_FETCH;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_valid_q <= skid_valid_d;
      instr        <= instr_d;
      pc           <= pc_d;
      clk_en       <= clk_en_d;
      instr_req    <= instr_req_d;
      instr_addr   <= instr_addr_d;
    end
  end

endmodule

// File: tb/tb_instr_fe.sv
// Directed bench for instr_fe with a small memory responder.
module tb_instr_fe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        clk_en;
  logic        stall;
  logic        flush;
  logic        change_pc;
  logic [31:0] new_pc;

  int n_vec = 0;
  int n_err = 0;

  // Memory responder: ack after ack_wait waiting cycles unless blocked.
  int   ack_wait  = 0;
  int   wait_cnt  = 0;
  logic mem_block = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  assign instr_ack  = instr_req && !mem_block && (wait_cnt >= ack_wait);
  assign instr_data = instr_ack ? mem_word(instr_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!rstn || !instr_req || instr_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  always #5 clk = ~clk;

  instr_fe dut (
    .clk        (clk),
    .rstn       (rstn),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .instr      (instr),
    .pc         (pc),
    .clk_en     (clk_en),
    .stall      (stall),
    .flush      (flush),
    .change_pc  (change_pc),
    .new_pc     (new_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then land on the following falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Reset for one edge, check reset outputs, release and take the IDLE edge.
  task automatic do_reset(input int aw);
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; change_pc = 1'b0; new_pc = 32'h0;
    ack_wait = aw; mem_block = 1'b0;
    tick();
    check("rst_req",    32'(instr_req), 32'd0);
    check("rst_pc",     pc,             32'h0);
    check("rst_instr",  instr,          32'h0000_0013);
    check("rst_clk_en", 32'(clk_en),    32'd0);
    rstn = 1'b1;
    tick();
    check("idle_req",  32'(instr_req), 32'd1);
    check("idle_addr", instr_addr,     32'h0);
    check("idle_en",   32'(clk_en),    32'd0);
  endtask

  initial begin
    // Zero-wait streaming.
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("zw_en",    32'(clk_en), 32'd1);
      check("zw_pc",    pc,          32'(4 * k));
      check("zw_instr", instr,       mem_word(32'(4 * k)));
      check("zw_addr",  instr_addr,  32'(4 * k + 4));
    end

    // Two-cycle memory: bubble every other cycle, address held while waiting.
    do_reset(1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("lat_bubble", 32'(clk_en), 32'd0);
      check("lat_hold",   instr_addr,  32'(4 * k));
      tick();
      check("lat_en",    32'(clk_en), 32'd1);
      check("lat_pc",    pc,          32'(4 * k));
      check("lat_instr", instr,       mem_word(32'(4 * k)));
      check("lat_next",  instr_addr,  32'(4 * k + 4));
    end

    // Stall for three edges while 8 returns; the skid holds it.
    do_reset(0);
    tick(); tick();
    stall = 1'b1;
    tick();
    check("stl_pc",  pc,             32'h4);
    check("stl_en",  32'(clk_en),    32'd1);
    check("stl_req", 32'(instr_req), 32'd0);
    tick(); tick();
    check("stl_pc3",  pc,             32'h4);
    check("stl_ins3", instr,          mem_word(32'h4));
    check("stl_req3", 32'(instr_req), 32'd0);
    stall = 1'b0;
    tick();
    check("skid_pc",    pc,             32'h8);
    check("skid_instr", instr,          mem_word(32'h8));
    check("skid_en",    32'(clk_en),    32'd1);
    check("skid_req",   32'(instr_req), 32'd1);
    check("skid_addr",  instr_addr,     32'hC);
    tick();
    check("post_skid_pc", pc, 32'hC);

    // Flush overrides stall and empties a full skid.
    do_reset(0);
    tick(); tick();
    stall = 1'b1;
    tick(); tick();
    flush = 1'b1;
    tick();
    check("fls_en",   32'(clk_en),    32'd0);
    check("fls_req",  32'(instr_req), 32'd1);
    check("fls_addr", instr_addr,     32'hC);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("fls_pc", pc,          32'hC);
    check("fls_on", 32'(clk_en), 32'd1);

    // Flush without stall drops the ack and keeps fetch_pc.
    do_reset(0);
    tick(); tick();
    flush = 1'b1;
    tick();
    check("fl_en",   32'(clk_en), 32'd0);
    check("fl_addr", instr_addr,  32'h8);
    check("fl_pc",   pc,          32'h4);
    flush = 1'b0;
    tick();
    check("fl_resume", pc, 32'h8);

    // Redirect during a pending request to 0x10 goes through DISCARD.
    do_reset(0);
    tick(); tick(); tick(); tick();
    mem_block = 1'b1;
    tick();
    check("pend_en",   32'(clk_en), 32'd0);
    check("pend_addr", instr_addr,  32'h10);
    change_pc = 1'b1; new_pc = 32'h0000_0102;
    tick();
    change_pc = 1'b0;
    check("dis_req",  32'(instr_req), 32'd1);
    check("dis_addr", instr_addr,     32'h10);
    check("dis_en",   32'(clk_en),    32'd0);
    tick();
    check("dis_hold", instr_addr, 32'h10);
    mem_block = 1'b0;
    tick();
    check("dis_drop_en",    32'(clk_en), 32'd0);
    check("dis_drop_instr", instr,       mem_word(32'hC));
    check("dis_new_addr",   instr_addr,  32'h100);
    tick();
    check("redir_pc",    pc,          32'h100);
    check("redir_instr", instr,       mem_word(32'h100));
    check("redir_en",    32'(clk_en), 32'd1);

    // Redirect coinciding with an ack drops the data.
    do_reset(0);
    tick(); tick();
    change_pc = 1'b1; new_pc = 32'h0000_0040;
    tick();
    change_pc = 1'b0;
    check("cack_en",   32'(clk_en), 32'd0);
    check("cack_addr", instr_addr,  32'h40);
    check("cack_pc",   pc,          32'h4);
    tick();
    check("cack_new", pc,    32'h40);
    check("cack_ins", instr, mem_word(32'h40));

    // Address wraps from 0xFFFF_FFFC to 0.
    do_reset(0);
    change_pc = 1'b1; new_pc = 32'hFFFF_FFFE;
    tick();
    change_pc = 1'b0;
    check("wrap_addr0", instr_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc",   pc,         32'hFFFF_FFFC);
    check("wrap_addr", instr_addr, 32'h0);
    tick();
    check("wrap_pc0", pc, 32'h0);

    // Reset mid-request restarts at PC_RESET.
    do_reset(0);
    tick(); tick();
    mem_block = 1'b1;
    tick();
    check("mid_addr", instr_addr, 32'h8);
    rstn = 1'b0;
    tick();
    check("mid_req",   32'(instr_req), 32'd0);
    check("mid_pc",    pc,             32'h0);
    check("mid_instr", instr,          32'h0000_0013);
    check("mid_en",    32'(clk_en),    32'd0);
    mem_block = 1'b0;
    rstn = 1'b1;
    tick();
    check("mid_addr0", instr_addr,  32'h0);
    check("mid_en0",   32'(clk_en), 32'd0);
    tick();
    check("mid_pc0",  pc,          32'h0);
    check("mid_ins0", instr,       mem_word(32'h0));
    check("mid_on",   32'(clk_en), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
